// File: rtl/div_calib_sequencer.sv
// ---------------------------------------------------------------------------
// div_calib_sequencer
//
// Multi-pass calibration controller for the pulse-duration / divider-adjust
// datapath. After a start pulse it repeatedly measures the high time of
// i_PSI, compares it with i_setPeriod and nudges o_adjustedDiv up or down
// until LOCK_COUNT consecutive passes match exactly (lock). It gives up
// after MAX_PASSES passes, or when no pulse edge arrives within TIMEOUT
// clocks.
//
// Optional build macro:
//   DIV_CALIB_COARSE_STEP_EN - the adjust step starts at 2^(W-4) on every
//   start and halves (never below 1) each time the adjust direction
//   reverses. Without the macro the step is always 1. W must be at least 5
//   when the macro is defined.
//
// Ports:
//   i_clk           system clock, all logic on the rising edge
//   i_rst           asynchronous, active-low reset
//   i_start         single-cycle pulse, begins a calibration run
//   i_abort         single-cycle pulse, cancels the run and returns to idle
//   i_PSI           measured pulse input, sampled every clock
//   i_setPeriod     target high time in clock samples
//   o_adjustedDiv   current divider value (registered)
//   o_duration      last or ongoing measured high time (registered)
//   o_busy          high while arming, measuring or adjusting
//   o_locked        high in the locked state
//   o_fail          high in the fail state
//   o_timeout_err   set when the fail was caused by a timeout
//   o_pass_cnt      passes completed in the current run
// ---------------------------------------------------------------------------
module div_calib_sequencer #(
    parameter int             W          = 8,
    parameter int             MAX_PASSES = 32,
    parameter int             LOCK_COUNT = 2,
    parameter int             TIMEOUT    = 255,
    parameter logic [W-1:0]   DIV_INIT   = 'h7F
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_abort,
    input  logic         i_PSI,
    input  logic [W-1:0] i_setPeriod,
    output logic [W-1:0] o_adjustedDiv,
    output logic [W-1:0] o_duration,
    output logic         o_busy,
    output logic         o_locked,
    output logic         o_fail,
    output logic         o_timeout_err,
    output logic [5:0]   o_pass_cnt
);

    localparam int WC_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_MEASURE,
        S_ADJUST,
        S_LOCKED,
        S_FAIL
    } state_t;

    state_t            r_state;
    logic              r_prePsi;
    logic [W-1:0]      r_adjustedDiv;
    logic [W-1:0]      r_duration;
    logic [5:0]        r_passCnt;
    logic [2:0]        r_matchCnt;
    logic [WC_W-1:0]   r_waitCnt;
    logic              r_busy;
    logic              r_locked;
    logic              r_fail;
    logic              r_timeoutErr;

`ifdef DIV_CALIB_COARSE_STEP_EN
    logic [W-1:0]      r_step;
    logic              r_dirUp;
    logic              r_dirValid;
`endif

    logic              w_rise;
    logic              w_fall;
    logic [WC_W-1:0]   w_waitInc;
    logic              w_waitHit;
    logic              w_greater;
    logic              w_less;
    logic [W-1:0]      w_stepEff;
    logic [W:0]        w_sum;
    logic [W-1:0]      w_divUp;
    logic [W-1:0]      w_divDown;
    logic [5:0]        w_passNext;
    logic [2:0]        w_matchNext;

    assign w_rise = ~r_prePsi & i_PSI;
    assign w_fall = r_prePsi & ~i_PSI;

    // The timeout fires on the cycle where the wait counter would reach TIMEOUT.
    assign w_waitInc = r_waitCnt + 1'b1;
    assign w_waitHit = (w_waitInc == WC_W'(TIMEOUT));

    assign w_greater = (r_duration > i_setPeriod);
    assign w_less    = (r_duration < i_setPeriod);

    // Effective adjust step. In coarse mode a direction reversal against the
    // previous non-equal pass halves the step before it is applied.
`ifdef DIV_CALIB_COARSE_STEP_EN
    always_comb begin
        w_stepEff = r_step;
        if (r_dirValid && (w_greater || w_less) && (w_greater != r_dirUp)) begin
            if ((r_step >> 1) == '0) begin
                w_stepEff = W'(1);
            end else begin
                w_stepEff = r_step >> 1;
            end
        end
    end
`else
    assign w_stepEff = W'(1);
`endif

    // Saturating divider arithmetic and the post-update pass/match counts
    // that decide the exit from ADJUST.
    always_comb begin
        w_sum = {1'b0, r_adjustedDiv} + {1'b0, w_stepEff};
        w_divUp = w_sum[W] ? '1 : w_sum[W-1:0];
        w_divDown = (r_adjustedDiv < w_stepEff) ? '0 : (r_adjustedDiv - w_stepEff);
        w_passNext = r_passCnt + 6'd1;
        if (w_greater || w_less) begin
            w_matchNext = 3'd0;
        end else begin
            w_matchNext = r_matchCnt + 3'd1;
        end
    end

    // Main sequencer: state, counters, datapath registers and status flags.
    // Abort outranks every other event, including a same-cycle start.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state       <= S_IDLE;
            r_prePsi      <= 1'b0;
            r_adjustedDiv <= DIV_INIT;
            r_duration    <= '0;
            r_passCnt     <= '0;
            r_matchCnt    <= '0;
            r_waitCnt     <= '0;
            r_busy        <= 1'b0;
            r_locked      <= 1'b0;
            r_fail        <= 1'b0;
            r_timeoutErr  <= 1'b0;
`ifdef DIV_CALIB_COARSE_STEP_EN
            r_step        <= W'(1 << (W - 4));
            r_dirUp       <= 1'b0;
            r_dirValid    <= 1'b0;
`endif
        end else begin
            r_prePsi <= i_PSI;
            if (i_abort) begin
                r_state      <= S_IDLE;
                r_busy       <= 1'b0;
                r_locked     <= 1'b0;
                r_fail       <= 1'b0;
                r_timeoutErr <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE, S_LOCKED, S_FAIL: begin
                        if (i_start) begin
                            r_state      <= S_ARM;
                            r_passCnt    <= '0;
                            r_matchCnt   <= '0;
                            r_waitCnt    <= '0;
                            r_busy       <= 1'b1;
                            r_locked     <= 1'b0;
                            r_fail       <= 1'b0;
                            r_timeoutErr <= 1'b0;
`ifdef DIV_CALIB_COARSE_STEP_EN
                            r_step       <= W'(1 << (W - 4));
                            r_dirUp      <= 1'b0;
                            r_dirValid   <= 1'b0;
`endif
                        end
                    end

                    S_ARM: begin
                        if (w_rise) begin
                            r_state    <= S_MEASURE;
                            r_duration <= '0;
                            r_waitCnt  <= '0;
                        end else if (w_waitHit) begin
                            r_state      <= S_FAIL;
                            r_busy       <= 1'b0;
                            r_fail       <= 1'b1;
                            r_timeoutErr <= 1'b1;
                        end else begin
                            r_waitCnt <= w_waitInc;
                        end
                    end

                    S_MEASURE: begin
                        if (w_fall) begin
                            r_state <= S_ADJUST;
                        end else if (w_waitHit) begin
                            r_state      <= S_FAIL;
                            r_busy       <= 1'b0;
                            r_fail       <= 1'b1;
                            r_timeoutErr <= 1'b1;
                        end else begin
                            r_waitCnt <= w_waitInc;
                            // The rising-edge sample itself is not counted,
                            // so H high samples measure as H-1.
                            if (r_prePsi && i_PSI && (r_duration != '1)) begin
                                r_duration <= r_duration + 1'b1;
                            end
                        end
                    end

                    S_ADJUST: begin
                        r_passCnt  <= w_passNext;
                        r_matchCnt <= w_matchNext;
                        if (w_greater) begin
                            r_adjustedDiv <= w_divUp;
                        end else if (w_less) begin
                            r_adjustedDiv <= w_divDown;
                        end
`ifdef DIV_CALIB_COARSE_STEP_EN
                        if (w_greater || w_less) begin
                            r_step     <= w_stepEff;
                            r_dirUp    <= w_greater;
                            r_dirValid <= 1'b1;
                        end
`endif
                        if (w_matchNext == 3'(LOCK_COUNT)) begin
                            r_state  <= S_LOCKED;
                            r_busy   <= 1'b0;
                            r_locked <= 1'b1;
                        end else if (w_passNext == 6'(MAX_PASSES)) begin
                            r_state <= S_FAIL;
                            r_busy  <= 1'b0;
                            r_fail  <= 1'b1;
                        end else begin
                            r_state   <= S_ARM;
                            r_waitCnt <= '0;
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_adjustedDiv = r_adjustedDiv;
    assign o_duration    = r_duration;
    assign o_busy        = r_busy;
    assign o_locked      = r_locked;
    assign o_fail        = r_fail;
    assign o_timeout_err = r_timeoutErr;
    assign o_pass_cnt    = r_passCnt;

endmodule

// File: tb/tb_div_calib_sequencer.sv
// ---------------------------------------------------------------------------
// tb_div_calib_sequencer
//
// Directed testbench for div_calib_sequencer with default parameters
// (W=8, MAX_PASSES=32, LOCK_COUNT=2, TIMEOUT=255, DIV_INIT=8'h7F).
// Inputs change and outputs are sampled on the falling clock edge.
// Expected divider values depend on DIV_CALIB_COARSE_STEP_EN.
// ---------------------------------------------------------------------------
module tb_div_calib_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       psi;
    logic [7:0] setPeriod;
    logic [7:0] adjustedDiv;
    logic [7:0] duration;
    logic       busy;
    logic       locked;
    logic       fail;
    logic       timeoutErr;
    logic [5:0] passCnt;

    int checks = 0;
    int errors = 0;

`ifdef DIV_CALIB_COARSE_STEP_EN
    localparam logic [7:0] EXP_T2_DIV  = 8'h8F;
    localparam logic [7:0] EXP_T3_DIV  = 8'h00;
    localparam logic [7:0] EXP_T5_DIV  = 8'h10;
`else
    localparam logic [7:0] EXP_T2_DIV  = 8'h80;
    localparam logic [7:0] EXP_T3_DIV  = 8'h5F;
    localparam logic [7:0] EXP_T5_DIV  = 8'h60;
`endif

    div_calib_sequencer dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_abort       (abort),
        .i_PSI         (psi),
        .i_setPeriod   (setPeriod),
        .o_adjustedDiv (adjustedDiv),
        .o_duration    (duration),
        .o_busy        (busy),
        .o_locked      (locked),
        .o_fail        (fail),
        .o_timeout_err (timeoutErr),
        .o_pass_cnt    (passCnt)
    );

    always #5 clk = ~clk;

    // One comparison: counts it, and on mismatch counts and reports the failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Single-cycle start/abort pulse, ending on the falling edge after it.
    task automatic applyStimulus(input logic s, input logic a);
        @(negedge clk);
        start = s;
        abort = a;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    // PSI high for h samples, then low long enough for ADJUST to finish.
    task automatic runPulse(input int h);
        repeat (h) begin
            @(negedge clk);
            psi = 1'b1;
        end
        repeat (4) begin
            @(negedge clk);
            psi = 1'b0;
        end
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        psi       = 1'b0;
        setPeriod = 8'd10;

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rst_div",     adjustedDiv, 8'h7F);
        checkOutput("rst_dur",     duration,    8'd0);
        checkOutput("rst_pass",    passCnt,     6'd0);
        checkOutput("rst_busy",    busy,        1'b0);
        checkOutput("rst_locked",  locked,      1'b0);
        checkOutput("rst_fail",    fail,        1'b0);
        checkOutput("rst_timeout", timeoutErr,  1'b0);
        rst = 1'b1;

        // Exact match twice -> lock
        applyStimulus(1'b1, 1'b0);
        checkOutput("t1_busy_arm", busy, 1'b1);
        runPulse(11);
        checkOutput("t1_dur1",  duration,    8'd10);
        checkOutput("t1_div1",  adjustedDiv, 8'h7F);
        checkOutput("t1_pass1", passCnt,     6'd1);
        checkOutput("t1_busy1", busy,        1'b1);
        runPulse(11);
        checkOutput("t1_locked", locked,      1'b1);
        checkOutput("t1_pass2",  passCnt,     6'd2);
        checkOutput("t1_div2",   adjustedDiv, 8'h7F);
        checkOutput("t1_busy2",  busy,        1'b0);

        // Long pulse nudges up, then two matches lock
        applyStimulus(1'b1, 1'b0);
        checkOutput("t2_unlocked", locked, 1'b0);
        runPulse(16);
        checkOutput("t2_dur15", duration,    8'd15);
        checkOutput("t2_divup", adjustedDiv, EXP_T2_DIV);
        runPulse(11);
        runPulse(11);
        checkOutput("t2_locked", locked,      1'b1);
        checkOutput("t2_pass3",  passCnt,     6'd3);
        checkOutput("t2_div",    adjustedDiv, EXP_T2_DIV);

        // Pass exhaustion from a fresh reset
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        setPeriod = 8'd200;
        applyStimulus(1'b1, 1'b0);
        for (int p = 0; p < 32; p++) begin
            runPulse(5);
        end
        checkOutput("t3_dur4",    duration,    8'd4);
        checkOutput("t3_div",     adjustedDiv, EXP_T3_DIV);
        checkOutput("t3_fail",    fail,        1'b1);
        checkOutput("t3_timeout", timeoutErr,  1'b0);
        checkOutput("t3_pass32",  passCnt,     6'd32);
        checkOutput("t3_locked",  locked,      1'b0);

        // Timeout in ARM with PSI held low
        applyStimulus(1'b1, 1'b0);
        checkOutput("t4_failclr", fail, 1'b0);
        repeat (254) @(negedge clk);
        checkOutput("t4_busy_edge", busy, 1'b1);
        @(negedge clk);
        checkOutput("t4_fail",    fail,       1'b1);
        checkOutput("t4_timeout", timeoutErr, 1'b1);
        checkOutput("t4_busy",    busy,       1'b0);

        // Abort from FAIL clears flags
        applyStimulus(1'b0, 1'b1);
        checkOutput("t5_abort_fail",    fail,       1'b0);
        checkOutput("t5_abort_timeout", timeoutErr, 1'b0);

        // Abort together with start in the middle of MEASURE
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        psi   = 1'b1;
        repeat (2) @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        psi   = 1'b0;
        checkOutput("t5_busy",   busy,        1'b0);
        checkOutput("t5_dur",    duration,    8'd2);
        checkOutput("t5_div",    adjustedDiv, EXP_T3_DIV);
        checkOutput("t5_locked", locked,      1'b0);
        checkOutput("t5_fail",   fail,        1'b0);
        @(negedge clk);
        checkOutput("t5_idle_hold", busy, 1'b0);

        // Asynchronous reset in the middle of a run
        setPeriod = 8'd10;
        applyStimulus(1'b1, 1'b0);
        runPulse(16);
        checkOutput("t6_div_pre",  adjustedDiv, EXP_T5_DIV);
        checkOutput("t6_busy_pre", busy,        1'b1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("t6_div_rst",  adjustedDiv, 8'h7F);
        checkOutput("t6_busy_rst", busy,        1'b0);
        checkOutput("t6_pass_rst", passCnt,     6'd0);
        checkOutput("t6_dur_rst",  duration,    8'd0);
        @(negedge clk);
        rst = 1'b1;

`ifdef DIV_CALIB_COARSE_STEP_EN
        // Coarse step halves on each direction reversal: 16, 8, 4
        setPeriod = 8'd10;
        applyStimulus(1'b1, 1'b0);
        runPulse(21);
        checkOutput("c_div1", adjustedDiv, 8'h8F);
        runPulse(6);
        checkOutput("c_div2", adjustedDiv, 8'h87);
        runPulse(21);
        checkOutput("c_div3", adjustedDiv, 8'h8B);
        checkOutput("c_pass", passCnt,     6'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
